// File: rtl/byte_mem_lsu_if.sv
// byte_mem_lsu_if: valid/ready load/store request and response bundle for
// byte_mem_lsu. The master modport is the requester (frisc memory stage);
// the slave modport is the memory unit.
interface byte_mem_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [8*DATA_BYTES-1:0] req_wdata;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [8*DATA_BYTES-1:0] resp_rdata;
  logic                    resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/byte_mem_lsu.sv
// byte_mem_lsu: byte-addressable data memory with byte/half/word loads and
// stores, sign/zero extension, bounds checking and registered responses.
// Accesses that straddle a row boundary are serviced over two cycles
// (IDLE -> SPLIT -> RESP).
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses are rejected
// with resp_err instead of being split.
module byte_mem_lsu #(
  parameter int SIZE       = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4
) (
  input logic           clk,
  input logic           reset,
  byte_mem_lsu_if.slave bus
);
  localparam int DW   = 8 * DATA_BYTES;
  localparam int ROWS = SIZE / DATA_BYTES;
  localparam int OFFW = $clog2(DATA_BYTES);
  localparam int ROWW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_t;

  state_t r_state;
  state_t w_nextState;

  // One array per byte bank; bank index is the low address bits.
  logic [7:0] r_mem [DATA_BYTES][ROWS];

  // Request fields held across the SPLIT cycle.
  logic [ROWW-1:0] r_row;
  logic [OFFW-1:0] r_off;
  logic [OFFW:0]   r_nbytes;
  logic            r_write;
  logic            r_signed;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_raw;
  logic [DW-1:0]   r_rdata;
  logic            r_err;

  // Request decode.
  logic [OFFW-1:0]     w_reqOff;
  logic [ROWW-1:0]     w_reqRow;
  logic [OFFW:0]       w_reqN;
  logic [ADDR_WIDTH:0] w_reqEnd;
  logic                w_reqErr;
  logic                w_reqCross;
  logic                w_accept;
  logic                w_respDone;
  logic                w_fire;

  // Current-phase view of the access (request in IDLE, held fields in SPLIT).
  logic [ROWW-1:0] w_curRow;
  logic [OFFW-1:0] w_curOff;
  logic [OFFW:0]   w_curN;
  logic            w_curPhase;
  logic            w_curWrite;
  logic            w_curSigned;
  logic [DW-1:0]   w_curWdata;
  logic [DW-1:0]   w_curRaw;

  // Byte-lane results.
  logic [DW-1:0] w_merged;
  logic [DW-1:0] w_ext;
  logic          w_we    [DATA_BYTES];
  logic [7:0]    w_wbyte [DATA_BYTES];

  assign w_reqOff   = bus.req_addr[OFFW-1:0];
  assign w_reqRow   = bus.req_addr[OFFW +: ROWW];
  assign w_accept   = bus.req_valid && bus.req_ready;
  assign w_respDone = (r_state == RESP) && bus.resp_ready;
  assign w_fire     = (w_accept && !w_reqErr) || (r_state == SPLIT);

  // Size decode, range check (one extra bit so the end address cannot wrap)
  // and row-crossing detection for the incoming request.
  always_comb begin
    w_reqN = (OFFW+1)'(1);
    case (bus.req_size)
      2'd0:    w_reqN = (OFFW+1)'(1);
      2'd1:    w_reqN = (OFFW+1)'(2);
      2'd2:    w_reqN = (OFFW+1)'(DATA_BYTES);
      default: w_reqN = (OFFW+1)'(1);
    endcase
    w_reqEnd = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(w_reqN) - (ADDR_WIDTH+1)'(1);
    w_reqErr = (bus.req_size == 2'd3) || (w_reqEnd >= (ADDR_WIDTH+1)'(SIZE));
`ifdef MISALIGN_TRAP_EN
    if ((w_reqOff & OFFW'(w_reqN - (OFFW+1)'(1))) != '0) begin
      w_reqErr = 1'b1;
    end
`endif
    w_reqCross = !w_reqErr && ((int'(w_reqOff) + int'(w_reqN)) > DATA_BYTES);
  end

  // Select which access the byte lanes work on this cycle: the live request
  // for the first row, or the held request for the second row of a split.
  always_comb begin
    if (r_state == SPLIT) begin
      w_curRow    = r_row;
      w_curOff    = r_off;
      w_curN      = r_nbytes;
      w_curPhase  = 1'b1;
      w_curWrite  = r_write;
      w_curSigned = r_signed;
      w_curWdata  = r_wdata;
      w_curRaw    = r_raw;
    end else begin
      w_curRow    = w_reqRow;
      w_curOff    = w_reqOff;
      w_curN      = w_reqN;
      w_curPhase  = 1'b0;
      w_curWrite  = bus.req_write;
      w_curSigned = bus.req_signed;
      w_curWdata  = bus.req_wdata;
      w_curRaw    = '0;
    end
  end

  // Map access byte k to its bank; bytes whose position runs past the row
  // end belong to the second phase. Reads merge into w_merged in address
  // order, writes raise the bank enable of the matching lane.
  always_comb begin
    int pos;
    logic [OFFW-1:0] bankIdx;
    logic active;
    w_merged = w_curRaw;
    for (int b = 0; b < DATA_BYTES; b++) begin
      w_we[b]    = 1'b0;
      w_wbyte[b] = 8'h00;
    end
    for (int k = 0; k < DATA_BYTES; k++) begin
      pos     = int'(w_curOff) + k;
      bankIdx = OFFW'(pos);
      active  = (k < int'(w_curN)) && ((pos >= DATA_BYTES) == w_curPhase);
      if (active) begin
        w_merged[8*k +: 8] = r_mem[bankIdx][w_curRow];
        if (w_curWrite && w_fire) begin
          w_we[bankIdx]    = 1'b1;
          w_wbyte[bankIdx] = w_curWdata[8*k +: 8];
        end
      end
    end
  end

  // Right-justified load result: bytes above the access size take the top
  // byte's MSB for signed loads, zero otherwise.
  always_comb begin
    logic sgn;
    sgn   = 1'b0;
    w_ext = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (k == int'(w_curN) - 1) begin
        sgn = w_merged[8*k + 7];
      end
    end
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (k < int'(w_curN)) begin
        w_ext[8*k +: 8] = w_merged[8*k +: 8];
      end else begin
        w_ext[8*k +: 8] = {8{w_curSigned & sgn}};
      end
    end
  end

  // Byte-bank storage writes; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (w_we[b]) begin
        r_mem[b][w_curRow] <= w_wbyte[b];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: errors and single-row accesses respond after one
  // cycle, row-crossing accesses take the extra SPLIT cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = w_reqCross ? SPLIT : RESP;
        end
      end
      SPLIT:   w_nextState = RESP;
      RESP: begin
        if (bus.resp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state; no new request during reset.
  always_comb begin
    bus.req_ready  = (r_state == IDLE) && reset;
    bus.resp_valid = (r_state == RESP);
    bus.resp_rdata = r_rdata;
    bus.resp_err   = r_err;
  end

  // Capture request fields and the first-row read at acceptance, finish the
  // merge in SPLIT, and hold the response until it is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row    <= '0;
      r_off    <= '0;
      r_nbytes <= '0;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_wdata  <= '0;
      r_raw    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_row    <= w_reqRow + ROWW'(1);
        r_off    <= w_reqOff;
        r_nbytes <= w_reqN;
        r_write  <= bus.req_write;
        r_signed <= bus.req_signed;
        r_wdata  <= bus.req_wdata;
        r_raw    <= w_merged;
        r_err    <= w_reqErr;
        if (w_reqErr || bus.req_write || w_reqCross) begin
          r_rdata <= '0;
        end else begin
          r_rdata <= w_ext;
        end
      end else if (r_state == SPLIT) begin
        r_err   <= 1'b0;
        r_rdata <= r_write ? '0 : w_ext;
      end else if (w_respDone) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_byte_mem_lsu.sv
// tb_byte_mem_lsu: directed and random load/store traffic against
// byte_mem_lsu, checked against a byte-array reference of the memory.
// Honours MISALIGN_TRAP_EN when the design is built with it.
module tb_byte_mem_lsu;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  byte_mem_lsu_if #(.ADDR_WIDTH(32), .DATA_BYTES(4)) bus();

  byte_mem_lsu #(.SIZE(64), .ADDR_WIDTH(32), .DATA_BYTES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  logic [7:0] memModel [64];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: plain byte array, little-endian, rows of 4 bytes.
  task automatic modelAccess(input bit wr, input logic [1:0] sz, input bit sg,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic err, output logic [31:0] rd, output int lat);
    int n;
    longint lastByte;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lastByte = longint'(addr) + n - 1;
    err = (sz == 2'd3) || (lastByte >= 64);
`ifdef MISALIGN_TRAP_EN
    if ((addr % n) != 0) err = 1'b1;
`endif
    rd  = 32'h0;
    lat = 1;
    if (!err) begin
      if ((addr / 4) != ((addr + n - 1) / 4)) lat = 2;
      if (wr) begin
        for (int i = 0; i < n; i++) memModel[addr + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(memModel[addr + i]) << (8 * i));
        if (sg && n < 4 && memModel[addr + n - 1][7]) v = v | (32'hFFFFFFFF << (8 * n));
        rd = v;
      end
    end
  endtask

  // One complete transaction; hold keeps resp_ready low that many extra
  // cycles. Returns the observed read data.
  task automatic applyStimulus(input bit wr, input logic [1:0] sz, input bit sg,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input int hold, input string tag,
                               output logic [31:0] gotData);
    logic expErr;
    logic [31:0] expData;
    int expLat;
    int cyc;
    modelAccess(wr, sz, sg, addr, wd, expErr, expData, expLat);
    @(negedge clk);
    checkOutput({tag, "_reqReady"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.resp_valid && cyc < 6) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(expLat));
    checkOutput({tag, "_err"}, 32'(bus.resp_err), 32'(expErr));
    checkOutput({tag, "_rdata"}, bus.resp_rdata, expData);
    gotData = bus.resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_holdValid"}, 32'(bus.resp_valid), 32'd1);
      checkOutput({tag, "_holdRdata"}, bus.resp_rdata, expData);
      checkOutput({tag, "_holdReady"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    checkOutput({tag, "_doneValid"}, 32'(bus.resp_valid), 32'd0);
    checkOutput({tag, "_doneReady"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_respValid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_respErr", 32'(bus.resp_err), 32'd0);
    checkOutput("rst_rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst_reqReadyLow", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_reqReady", 32'(bus.req_ready), 32'd1);

    // Fill memory with random words so the model knows every byte.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, 0, "init", got);
    end

    // Word store/load and extension cases.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'd0, 32'hDEADBEEF, 0, "stDeadbeef", got);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 0, "ldWord0", got);
    checkOutput("lit_ldWord0", got, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'd3, 32'h0, 0, "ldByte3s", got);
    checkOutput("lit_ldByte3s", got, 32'hFFFFFFDE);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'd3, 32'h0, 0, "ldByte3u", got);
    checkOutput("lit_ldByte3u", got, 32'h000000DE);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'd1, 32'h0, 0, "ldHalf1s", got);
`ifndef MISALIGN_TRAP_EN
    checkOutput("lit_ldHalf1s", got, 32'hFFFFADBE);
`endif

    // Row-crossing store and per-byte readback including neighbours.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'd6, 32'h11223344, 0, "stCross6", got);
    for (int a = 5; a <= 10; a++) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 32'(a), 32'h0, 0, "ldByteCross", got);
    end
`ifndef MISALIGN_TRAP_EN
    applyStimulus(1'b0, 2'd0, 1'b0, 32'd7, 32'h0, 0, "ldByte7", got);
    checkOutput("lit_ldByte7", got, 32'h00000033);
`endif

    // Bounds and reserved size.
    applyStimulus(1'b0, 2'd2, 1'b0, 32'd62, 32'h0, 0, "errWord62", got);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'd0, 32'h0, 0, "errSize3", got);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h55, 0, "errWrapAddr", got);

    // Back-pressure: response held for 5 cycles, then immediate next request.
    applyStimulus(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 5, "holdResp", got);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'd2, 32'h0, 0, "afterHold", got);

    // Random traffic, addresses reaching past the end of memory.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 66)),
                    $urandom, (i % 10 == 0) ? 2 : 0, "rand", got);
    end

    // Reset during the second cycle of a row-crossing store.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'd0, 32'h0, 0, "zeroRow0", got);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'd4, 32'h0, 0, "zeroRow1", got);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'd2;
    bus.req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("abort_respValid", 32'(bus.resp_valid), 32'd0);
    checkOutput("abort_rdata", bus.resp_rdata, 32'h0);
`ifndef MISALIGN_TRAP_EN
    memModel[2] = 8'hDD;
    memModel[3] = 8'hCC;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_noResp", 32'(bus.resp_valid), 32'd0);
    checkOutput("abort_ready", 32'(bus.req_ready), 32'd1);
    for (int a = 2; a <= 5; a++) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 32'(a), 32'h0, 0, "ldAbort", got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/byte_mem_lsu.md
Name: byte_mem_lsu

Overview:
- Parametrised byte-addressable data memory with a valid/ready load/store interface; the next generation of the team's frisc byte memory.
- Adds byte/half/word access sizes, sign/zero extension, bounds checking, and registered responses.
- Adds two-cycle split handling of accesses that straddle a row boundary.
- Sits between the frisc memory stage and on-chip data storage.

Parameters:
- SIZE, 64, memory capacity in bytes; must be a multiple of DATA_BYTES.
- ADDR_WIDTH, 32, byte address width.
- DATA_BYTES, 4, bytes per row/bank count (power of two, >=2); data width = 8*DATA_BYTES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word (DATA_BYTES bytes), 3 reserved.
- req_signed  in  1  sign-extend load result (ignored for stores/word).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  8*DATA_BYTES  store data, low-order bytes used.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  8*DATA_BYTES  load result, right-justified and extended; 0 for stores/errors.
- resp_err  out  1  request rejected (out of range or reserved size).

Behaviour:
- Storage: DATA_BYTES byte banks, SIZE/DATA_BYTES rows; byte at address A lives in bank A mod DATA_BYTES, row A/DATA_BYTES; little-endian. Contents are not reset.
- FSM states IDLE, SPLIT, RESP. req_ready = (state==IDLE); resp_valid = (state==RESP).
- Handshake: a request is accepted on an edge where req_valid && req_ready; request fields are captured at that edge. A response completes on an edge where resp_valid && resp_ready. Response outputs stay stable while resp_valid && !resp_ready.
- nbytes = 1/2/DATA_BYTES for size 0/1/2.
- Error: size==3, or req_addr+nbytes-1 >= SIZE (computed at ADDR_WIDTH+1 bits, no wrap). Error path: IDLE->RESP, resp_err=1, rdata=0, no memory write.
- Aligned or non-crossing access (all bytes in one row): at the accept edge, write enabled bytes; capture the read row. IDLE->RESP; resp_valid the cycle after acceptance (latency 1).
- Crossing access (spans rows r and r+1): accept edge handles row r bytes, IDLE->SPLIT; next edge handles row r+1 bytes, SPLIT->RESP (latency 2). Bytes are merged in address order.
- Load result: bytes 0..nbytes-1 from the address. Upper bits are filled with the MSB of the top byte if req_signed, else 0.
- RESP->IDLE on resp handshake; the next request can be accepted from the following cycle (max throughput 1 per 2 cycles aligned).
- A load accepted after a store completes observes the stored data.
- Reset asserted: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 while not in reset. Reset mid-SPLIT aborts the request: row r bytes already written stay written, row r+1 is untouched, no response is issued.

Optional Feature:
- MISALIGN_TRAP_EN defined: any access where req_addr mod nbytes != 0 is an error (resp_err=1, latency 1, no write); the SPLIT state is unreachable.
- Undefined: misaligned accesses are serviced, split as above.

Test Plan:
- Reset, store word 0xDEADBEEF @0, load word @0 -> resp_valid 1 cycle after accept, rdata 0xDEADBEEF, err 0.
- After above: load byte @3 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half @1 signed -> 0xFFFFADBE.
- Store word 0x11223344 @6 (crosses rows 1/2) -> resp 2 cycles after accept; load bytes @6..9 -> 0x44,0x33,0x22,0x11; bytes @5 and @10 unchanged. With MISALIGN_TRAP_EN -> err=1 after 1 cycle, memory unchanged.
- Load word @62 (SIZE=64) -> err=1, rdata 0, 1-cycle latency; size=3 @0 -> err=1.
- Hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable, req_ready=0 throughout; release -> IDLE, next request accepted the following cycle.
- Assert reset during SPLIT of store 0xAABBCCDD @2 (initial memory 0) -> resp_valid 0; bytes @2,3 = 0xDD,0xCC; bytes @4,5 = 0x00.
